// File: rtl/ask2_modulator_if.sv
// ask2_modulator_if: groups the 2ASK modulator's control inputs and its
// symbol/sample outputs into one bundle.
//   master modport : drives en, fcw, bit_in; observes all modulator outputs
//   slave  modport : the modulator side (receives controls, drives outputs)
// Signals:
//   en        run enable; low freezes all counters
//   fcw       carrier frequency control word
//   bit_in    serial data bit from the PN source
//   sym_clk   registered 50% symbol clock (PN source shifts on rising edge)
//   sym_stb   one-cycle pulse, a new bit was captured
//   bit_hold  currently keyed bit
//   carrier   signed unkeyed carrier sample
//   ask_out   signed keyed sample
//   ask_valid ask_out is valid
interface ask2_modulator_if #(
  parameter int PHASE_W = 16
);
  logic               en;
  logic [PHASE_W-1:0] fcw;
  logic               bit_in;
  logic               sym_clk;
  logic               sym_stb;
  logic               bit_hold;
  logic signed [7:0]  carrier;
  logic signed [7:0]  ask_out;
  logic               ask_valid;

  modport master (
    output en, fcw, bit_in,
    input  sym_clk, sym_stb, bit_hold, carrier, ask_out, ask_valid
  );

  modport slave (
    input  en, fcw, bit_in,
    output sym_clk, sym_stb, bit_hold, carrier, ask_out, ask_valid
  );
endinterface

// File: rtl/ask2_modulator.sv
// ask2_modulator: binary on-off-keying (2ASK) modulator.
// Generates a symbol clock for the upstream PN source, captures the PN bit
// half a symbol after each shift, and keys a 32-entry sine carrier with it.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ask2_modulator_if.slave (en, fcw, bit_in in; symbol and sample
//          outputs out)
// Parameters:
//   SYM_DIV  clk cycles per symbol (even, >= 4)
//   PHASE_W  phase accumulator width (>= 5)
module ask2_modulator #(
  parameter int SYM_DIV = 64,
  parameter int PHASE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ask2_modulator_if.slave      bus
);

  localparam int CNT_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SYM_DIV / 2);

  // Symbol timing / capture state
  logic [CNT_W-1:0]   r_sym_cnt;
  logic               r_sym_clk;
  logic               r_sym_stb;
  logic               r_bit_hold;
  logic [PHASE_W-1:0] r_phase;

  // Output pipeline
  logic signed [7:0]  r_carrier;
  logic               r_bit_d;
  logic               r_v1;
  logic signed [7:0]  r_ask_out;
  logic               r_ask_valid;

  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_capture;
  logic [4:0]         w_idx;
  logic signed [7:0]  w_lut;

  // Quarter-wave magnitude of round(127*sin(2*pi*k/32)) for k = 0..8.
  function automatic logic [6:0] quarter_mag(input logic [3:0] off);
    logic [6:0] m;
    case (off)
      4'd0:    m = 7'd0;
      4'd1:    m = 7'd25;
      4'd2:    m = 7'd49;
      4'd3:    m = 7'd71;
      4'd4:    m = 7'd90;
      4'd5:    m = 7'd106;
      4'd6:    m = 7'd117;
      4'd7:    m = 7'd125;
      default: m = 7'd127;
    endcase
    return m;
  endfunction

  // Full 32-entry table folded onto one quarter: k[3] mirrors the offset
  // within the half-period, k[4] negates for the second half.
  function automatic logic signed [7:0] sine_lut(input logic [4:0] k);
    logic [3:0]        off;
    logic signed [7:0] mag;
    off = k[3] ? (4'd8 - {1'b0, k[2:0]}) : {1'b0, k[2:0]};
    mag = $signed({1'b0, quarter_mag(off)});
    return k[4] ? -mag : mag;
  endfunction

  always_comb begin
    w_cnt_nxt = (r_sym_cnt == CNT_LAST) ? '0 : r_sym_cnt + 1'b1;
    w_capture = bus.en && (r_sym_cnt == CNT_HALF);
    w_idx     = r_phase[PHASE_W-1 -: 5];
    w_lut     = sine_lut(w_idx);
  end

  // Symbol counter, symbol clock, bit capture and phase accumulator.
  // sym_clk is loaded from the next count so it stays a clean register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_cnt  <= '0;
      r_sym_clk  <= 1'b1;
      r_sym_stb  <= 1'b0;
      r_bit_hold <= 1'b0;
      r_phase    <= '0;
    end else begin
      r_sym_stb <= w_capture;
      if (w_capture) begin
        r_bit_hold <= bus.bit_in;
      end
      if (bus.en) begin
        r_sym_cnt <= w_cnt_nxt;
        r_sym_clk <= (w_cnt_nxt < CNT_HALF);
        r_phase   <= r_phase + bus.fcw;
      end
    end
  end

  // Two-stage output pipeline; advances every cycle regardless of en so that
  // ask_valid drains and refills with a fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carrier   <= '0;
      r_bit_d     <= 1'b0;
      r_v1        <= 1'b0;
      r_ask_out   <= '0;
      r_ask_valid <= 1'b0;
    end else begin
      r_carrier   <= w_lut;
      r_bit_d     <= r_bit_hold;
      r_v1        <= bus.en;
      r_ask_out   <= (r_v1 && r_bit_d) ? r_carrier : '0;
      r_ask_valid <= r_v1;
    end
  end

  assign bus.sym_clk   = r_sym_clk;
  assign bus.sym_stb   = r_sym_stb;
  assign bus.bit_hold  = r_bit_hold;
  assign bus.carrier   = r_carrier;
  assign bus.ask_out   = r_ask_out;
  assign bus.ask_valid = r_ask_valid;

endmodule
